// File: rtl/pipe_adder_pkg.sv
// Shared constants and per-stage control bundle for pipe_adder.
// Optional subtract mode is enabled with PIPE_ADDER_SUB_EN.
package pipe_adder_pkg;

  localparam int PIPE_ADDER_N      = 32;
  localparam int PIPE_ADDER_STAGES = 4;

  // Wide operand remainders and partial sums live beside this bundle,
  // sized per stage, so no stage stores bits it no longer needs.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sa;
`ifdef PIPE_ADDER_SUB_EN
    logic sub;
`endif
    logic sb;
  } stage_t;

endpackage

// File: rtl/pipe_adder_slice.sv
// adder_slice: combinational W-bit add with carry in and carry out.
// Instantiated once per pipeline stage by pipe_adder.
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: carry-chain pipelined N-bit adder, STAGES slices deep.
// Define PIPE_ADDER_SUB_EN to add the sub port (a - b mode).
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int N      = PIPE_ADDER_N,
  parameter int STAGES = PIPE_ADDER_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int W = N / STAGES;

  if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: N must be a multiple of STAGES");
  end

  logic         stall;
  logic         advance;
  logic [N-1:0] b_eff;
  stage_t       head;
  stage_t       last;
  logic         sb_eff;

  always_comb begin
    head       = '0;
    head.valid = in_valid;
    head.sa    = a[N-1];
    head.sb    = b[N-1];
`ifdef PIPE_ADDER_SUB_EN
    head.sub   = sub;
    head.carry = sub | cin;
    b_eff      = sub ? ~b : b;
`else
    head.carry = cin;
    b_eff      = b;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = (k + 1) * W;
    localparam int RW = N - SW;

    stage_t        ctl_in;
    stage_t        ctl_d;
    stage_t        ctl_q;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  s;
    logic          co;
    logic [SW-1:0] acc_d;
    logic [SW-1:0] acc_q;

    if (k == 0) begin : g_src
      assign ctl_in = head;
      assign op_a   = a[W-1:0];
      assign op_b   = b_eff[W-1:0];
      assign acc_d  = s;
    end else begin : g_src
      assign ctl_in = g_stage[k-1].ctl_q;
      assign op_a   = g_stage[k-1].g_rem.rem_a[W-1:0];
      assign op_b   = g_stage[k-1].g_rem.rem_b[W-1:0];
      assign acc_d  = {s, g_stage[k-1].acc_q};
    end

    adder_slice #(
      .W(W)
    ) u_slice (
      .a    (op_a),
      .b    (op_b),
      .cin  (ctl_in.carry),
      .sum  (s),
      .cout (co)
    );

    always_comb begin
      ctl_d       = ctl_in;
      ctl_d.carry = co;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q <= '0;
        acc_q <= '0;
      end else if (advance) begin
        ctl_q <= ctl_d;
        acc_q <= acc_d;
      end
    end

    // Operand bits above this slice ride along until their stage.
    if (RW > 0) begin : g_rem
      logic [RW-1:0] rem_a;
      logic [RW-1:0] rem_b;
      logic [RW-1:0] nxt_a;
      logic [RW-1:0] nxt_b;

      if (k == 0) begin : g_fwd
        assign nxt_a = a[N-1:W];
        assign nxt_b = b_eff[N-1:W];
      end else begin : g_fwd
        assign nxt_a = g_stage[k-1].g_rem.rem_a[RW+W-1:W];
        assign nxt_b = g_stage[k-1].g_rem.rem_b[RW+W-1:W];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rem_a <= '0;
          rem_b <= '0;
        end else if (advance) begin
          rem_a <= nxt_a;
          rem_b <= nxt_b;
        end
      end
    end
  end

  assign last      = g_stage[STAGES-1].ctl_q;
  assign out_valid = last.valid;
  assign sum       = g_stage[STAGES-1].acc_q;
  assign cout      = last.carry;

`ifdef PIPE_ADDER_SUB_EN
  assign sb_eff = last.sb ^ last.sub;
`else
  assign sb_eff = last.sb;
`endif
  // Decoded from last-stage registers only; all-zero after reset.
  assign ovf = (last.sa == sb_eff) && (sum[N-1] != last.sa);

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

endmodule
